move_scheduler: RTL and testbench

Sequences move commands into the 2048 board engine and shares it between two direction sources: pushbutton pad (requester 0) and keyboard decoder (requester 1). Each requester offers a 2-bit direction over a valid/ready handshake. The scheduler round-robin arbitrates between them and issues exactly one single-cycle direction code to the engine. It then blocks new issues for the engine's fixed edit-sequence length so that no move lands mid-sequence.

---
 rtl/game_pkg.sv | 28 ++
 rtl/move_scheduler_if.sv | 29 ++
 rtl/rr_arbiter2.sv | 48 ++++
 rtl/move_scheduler.sv | 165 ++++++++++++++++
 tb/tb_move_scheduler.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared 2048 game definitions: direction encoding, the idle command code sent
// to the board engine, and the move scheduler state type.
// No ports (package).
// -----------------------------------------------------------------------------
package game_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t       DIR_UP    = 2'd0;
    localparam dir_t       DIR_RIGHT = 2'd1;
    localparam dir_t       DIR_DOWN  = 2'd2;
    localparam dir_t       DIR_LEFT  = 2'd3;
    localparam logic [2:0] DIR_IDLE  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } move_sched_state_t;

    // Engine command code for a move pulse in direction d.
    function automatic logic [2:0] dir_to_cmd(dir_t d);
        return {1'b0, d};
    endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// -----------------------------------------------------------------------------
// move_scheduler_if
// Bundles the two direction requesters' valid/ready handshake and the command
// outputs towards the board engine.
//   master : requesters + engine side (drives req_valid/req_dir*)
//   slave  : move_scheduler side (drives req_ready, cmd_dir, busy, move_count)
// -----------------------------------------------------------------------------
interface move_scheduler_if;
    import game_pkg::*;

    logic [1:0]  req_valid;
    dir_t        req_dir0;
    dir_t        req_dir1;
    logic [1:0]  req_ready;
    logic [2:0]  cmd_dir;
    logic        busy;
    logic [15:0] move_count;

    modport master (
        output req_valid, req_dir0, req_dir1,
        input  req_ready, cmd_dir, busy, move_count
    );

    modport slave (
        input  req_valid, req_dir0, req_dir1,
        output req_ready, cmd_dir, busy, move_count
    );

endinterface

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. A lone request always wins; on a tie the
// requester that was not granted last wins. last_grant only moves when the
// grant is actually consumed (advance_i).
// Ports:
//   clk, rst   : clock, synchronous active-high reset (last_grant -> 1)
//   req_i[1:0] : request vector
//   advance_i  : grant consumed this cycle
//   gnt_o[1:0] : one-hot grant (00 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (advance_i) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
// Shares the 2048 board engine between the pushbutton pad (requester 0) and the
// keyboard decoder (requester 1). Each accepted direction produces exactly one
// single-cycle command pulse, after which new pulses are held off for
// MOVE_CYCLES cycles while the engine runs its edit sequence.
// Optional feature macro: MOVE_SCHED_QUEUE_EN adds a one-entry pending slot so
// a request can be accepted while a move is still in flight.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (aborts any move)
//   bus.slave  : req_valid/req_dir0/req_dir1 in, req_ready (combinational),
//                cmd_dir/busy/move_count out (registered)
// -----------------------------------------------------------------------------
module move_scheduler
    import game_pkg::*;
#(
    parameter int MOVE_CYCLES = 42
) (
    input  logic              clk,
    input  logic              rst,
    move_scheduler_if.slave   bus
);

    localparam int CNT_W = $clog2(MOVE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = MOVE_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    move_sched_state_t state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        cmd_dir_q, cmd_dir_d;
    logic              busy_q, busy_d;
    logic [15:0]       move_count_q, move_count_d;

    logic [1:0] gnt;
    logic       accept;
    logic       xfer;
    dir_t       xfer_dir;
    logic       issue;
    dir_t       issue_dir;

`ifdef MOVE_SCHED_QUEUE_EN
    logic slot_full_q, slot_full_d;
    dir_t slot_dir_q, slot_dir_d;
`endif

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.req_valid),
        .advance_i (xfer),
        .gnt_o     (gnt)
    );

    // The winner may be offered ready even with valid low; no transfer then.
    always_comb begin
        accept = 1'b0;
        if (!rst) begin
`ifdef MOVE_SCHED_QUEUE_EN
            accept = (state_q == IDLE) || !slot_full_q;
`else
            accept = (state_q == IDLE);
`endif
        end
    end

    assign bus.req_ready = accept ? gnt : 2'b00;
    assign xfer          = |(bus.req_valid & bus.req_ready);
    assign xfer_dir      = gnt[1] ? bus.req_dir1 : bus.req_dir0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        issue     = 1'b0;
        issue_dir = xfer_dir;
`ifdef MOVE_SCHED_QUEUE_EN
        slot_full_d = slot_full_q;
        slot_dir_d  = slot_dir_q;
`endif
        unique case (state_q)
            IDLE: begin
                issue = xfer;
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CNT_LOAD;
`ifdef MOVE_SCHED_QUEUE_EN
                if (xfer) begin
                    slot_full_d = 1'b1;
                    slot_dir_d  = xfer_dir;
                end
`endif
            end
            WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
`ifdef MOVE_SCHED_QUEUE_EN
                    // A request accepted on the expiry cycle goes straight out
                    // instead of parking in the slot.
                    if (slot_full_q) begin
                        issue       = 1'b1;
                        issue_dir   = slot_dir_q;
                        slot_full_d = 1'b0;
                    end else begin
                        issue = xfer;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
`ifdef MOVE_SCHED_QUEUE_EN
                    if (xfer) begin
                        slot_full_d = 1'b1;
                        slot_dir_d  = xfer_dir;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            state_d = ISSUE;
        end

        // Outputs are registered from the next state so the pulse lines up
        // with the ISSUE cycle.
        cmd_dir_d    = issue ? dir_to_cmd(issue_dir) : DIR_IDLE;
        busy_d       = (state_d != IDLE);
        move_count_d = move_count_q + {15'd0, issue};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cmd_dir_q    <= DIR_IDLE;
            busy_q       <= 1'b0;
            move_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_dir_q    <= cmd_dir_d;
            busy_q       <= busy_d;
            move_count_q <= move_count_d;
        end
    end

`ifdef MOVE_SCHED_QUEUE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full_q <= 1'b0;
        end else begin
            slot_full_q <= slot_full_d;
        end
    end

    always_ff @(posedge clk) begin
        slot_dir_q <= slot_dir_d;
    end
`endif

    assign bus.cmd_dir    = cmd_dir_q;
    assign bus.busy       = busy_q;
    assign bus.move_count = move_count_q;

endmodule

// File: tb/tb_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_move_scheduler
// Directed scenarios followed by randomized traffic; every cycle the DUT is
// compared against a timeline model (pulse times, busy windows, grant history).
// Define MOVE_SCHED_QUEUE_EN for both RTL and bench to exercise the slot.
// -----------------------------------------------------------------------------
module tb_move_scheduler;
    import game_pkg::*;

    localparam int MC = 42;
`ifdef MOVE_SCHED_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    move_scheduler_if bus ();

    move_scheduler #(.MOVE_CYCLES(MC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Timeline model: a move pulsed at time P keeps the engine busy over
    // [P, P+MC]; at most one future pulse may be scheduled at once.
    int          cyc        = 0;
    int          last_pulse = -1000;
    int          sched_t    = -1;
    dir_t        sched_dir  = 2'd0;
    int          m_last     = 1;
    logic [15:0] m_count    = 16'd0;

    function automatic bit m_busy(input int c);
        return (c >= last_pulse) && (c <= last_pulse + MC);
    endfunction

    task automatic step(input bit r, input logic [1:0] v, input dir_t d0, input dir_t d1);
        logic [2:0] exp_cmd;
        logic [1:0] exp_rdy;
        logic [1:0] gnt;
        int         idx;
        bit         b;
        @(negedge clk);
        exp_cmd = DIR_IDLE;
        if (sched_t == cyc) begin
            last_pulse = cyc;
            exp_cmd    = {1'b0, sched_dir};
            m_count    = m_count + 16'd1;
            sched_t    = -1;
        end
        if (cyc > 0) begin
            check_eq("cmd_dir", 32'(bus.cmd_dir), 32'(exp_cmd));
            check_eq("busy", 32'(bus.busy), 32'(m_busy(cyc)));
            check_eq("move_count", 32'(bus.move_count), 32'(m_count));
        end
        rst           = r;
        bus.req_valid = v;
        bus.req_dir0  = d0;
        bus.req_dir1  = d1;
        #1;
        b   = m_busy(cyc);
        idx = -1;
        if (v == 2'b11)      idx = (m_last == 1) ? 0 : 1;
        else if (v == 2'b01) idx = 0;
        else if (v == 2'b10) idx = 1;
        gnt = (idx < 0) ? 2'b00 : 2'(1 << idx);
        exp_rdy = 2'b00;
        if (!r && (!b || (QUEUE && sched_t < 0))) exp_rdy = gnt;
        check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (r) begin
            last_pulse = -1000;
            sched_t    = -1;
            m_last     = 1;
            m_count    = 16'd0;
        end else if ((v & exp_rdy) != 2'b00) begin
            m_last    = idx;
            sched_dir = (idx == 1) ? d1 : d0;
            sched_t   = b ? (last_pulse + MC + 1) : (cyc + 1);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'd0, 2'd0);
    endtask

    initial begin
        bus.req_valid = 2'b00;
        bus.req_dir0  = 2'd0;
        bus.req_dir1  = 2'd0;

        step(1'b1, 2'b11, DIR_UP, DIR_LEFT);
        step(1'b1, 2'b00, DIR_UP, DIR_UP);
        idle(2);

        // Single request from requester 0.
        step(1'b0, 2'b01, DIR_DOWN, DIR_UP);
        idle(50);

        // Tie after a fresh reset, both held valid.
        step(1'b1, 2'b00, DIR_UP, DIR_UP);
        for (int i = 0; i < 100; i++) step(1'b0, 2'b11, DIR_UP, DIR_LEFT);
        idle(50);

        // Back-pressure: request held while busy.
        step(1'b0, 2'b10, DIR_RIGHT, DIR_RIGHT);
        for (int i = 0; i < 60; i++) step(1'b0, 2'b01, DIR_LEFT, DIR_UP);
        idle(50);

        // Second request during WAIT, third behind it.
        step(1'b0, 2'b01, DIR_DOWN, DIR_UP);
        idle(5);
        step(1'b0, 2'b10, DIR_UP, DIR_RIGHT);
        for (int i = 0; i < 20; i++) step(1'b0, 2'b01, DIR_LEFT, DIR_UP);
        idle(100);

        // Reset mid-WAIT.
        step(1'b0, 2'b01, DIR_RIGHT, DIR_UP);
        idle(11);
        step(1'b1, 2'b00, DIR_UP, DIR_UP);
        idle(5);

        // Counter wrap: preload all-ones while idle, then issue one move.
        for (int i = 0; i < 200 && (m_busy(cyc) || sched_t >= 0); i++) idle(1);
        check_eq("idle_before_wrap", 32'(m_busy(cyc) || sched_t >= 0), 32'd0);
        @(negedge clk);
        force dut.move_count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        @(negedge clk);
        release dut.move_count_q;
        cyc += 2;
        step(1'b0, 2'b01, DIR_LEFT, DIR_UP);
        idle(3);
        check_eq("wrap_count", 32'(bus.move_count), 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit         r;
            logic [1:0] v;
            r    = ($urandom_range(0, 399) == 0);
            v[0] = ($urandom_range(0, 3) == 0);
            v[1] = ($urandom_range(0, 3) == 0);
            step(r, v, dir_t'($urandom_range(0, 3)), dir_t'($urandom_range(0, 3)));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
